img_rsz_out_strm: RTL

IMG_RSZ_OUT_STRM -- requirements
Module: img_rsz_out_strm

---
 rtl/img_rsz_out_strm_pkg.sv | 30 +++
 rtl/img_rsz_out_strm_if.sv | 31 +++
 rtl/img_rsz_out_fifo.sv | 64 ++++++
 rtl/img_rsz_out_strm.sv | 116 +++++++++++
 4 files changed

// File: rtl/img_rsz_out_strm_pkg.sv
// Resizer shared types: pixel format, output image geometry, output-stream FIFO entry and FSM state.
package ImgRszPkg;

    localparam int RSZ_IMG_WIDTH_SIZE   = 2;
    localparam int RSZ_IMG_HEIGHT_SIZE  = 2;
    localparam int RSZ_IMG_WIDTH_IDX_W  = (RSZ_IMG_WIDTH_SIZE  > 1) ? $clog2(RSZ_IMG_WIDTH_SIZE)  : 1;
    localparam int RSZ_IMG_HEIGHT_IDX_W = (RSZ_IMG_HEIGHT_SIZE > 1) ? $clog2(RSZ_IMG_HEIGHT_SIZE) : 1;

    localparam logic [RSZ_IMG_WIDTH_IDX_W-1:0]  RSZ_X_LAST = RSZ_IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RSZ_Y_LAST = RSZ_IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } FcRszPxlData_t;

    typedef struct packed {
        FcRszPxlData_t data;
        logic          sof;
        logic          eol;
        logic          eof;
    } RszOutEntry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } RszOutState_e;

endpackage

// File: rtl/img_rsz_out_strm_if.sv
// Pixel-in / stream-out bundle of the resizer output streamer; slave is the streamer, master its environment.
interface img_rsz_out_strm_if
    import ImgRszPkg::*;
#(
    parameter int FRM_CNT_W = 16
);
    FcRszPxlData_t                   RszPxlData;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  RszPxlX;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RszPxlY;
    logic                            RszPxlVld;
    logic                            RszPxlRdy;
    FcRszPxlData_t                   OutData;
    logic                            OutSof;
    logic                            OutEol;
    logic                            OutEof;
    logic                            OutVld;
    logic                            OutRdy;
    logic [FRM_CNT_W-1:0]            FrmCnt;
    logic                            Busy;
    logic                            SeqErr;

    modport slave (
        input  RszPxlData, RszPxlX, RszPxlY, RszPxlVld, OutRdy,
        output RszPxlRdy, OutData, OutSof, OutEol, OutEof, OutVld, FrmCnt, Busy, SeqErr
    );

    modport master (
        output RszPxlData, RszPxlX, RszPxlY, RszPxlVld, OutRdy,
        input  RszPxlRdy, OutData, OutSof, OutEol, OutEof, OutVld, FrmCnt, Busy, SeqErr
    );
endinterface

// File: rtl/img_rsz_out_fifo.sv
// Small synchronous FIFO; ready is registered from the next-state count so it never depends on push.
module img_rsz_out_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     din_i,
    input  logic pop_i,
    output T     dout_o,
    output logic empty_o,
    output logic rdy_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & rdy_q;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= (cnt_d < CNT_FULL);
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign empty_o = (cnt_q == '0);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign rdy_o   = rdy_q;

endmodule

// File: rtl/img_rsz_out_strm.sv
// Resizer output streamer: tags pixels with SOF/EOL/EOF, buffers them, counts frames.
// Define IMG_RSZ_OUT_SEQ_CHK_EN to build the raster-order checker driving SeqErr.
module img_rsz_out_strm
    import ImgRszPkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FRM_CNT_W  = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    img_rsz_out_strm_if.slave  bus
);
    logic                 acc, pop, fifo_empty, fifo_rdy;
    logic                 in_sof, in_eol, in_eof;
    RszOutEntry_t         push_ent, pop_ent;
    RszOutState_e         state_q, state_d;
    logic [FRM_CNT_W-1:0] frm_cnt_q, frm_cnt_d;

    assign in_sof   = (bus.RszPxlX == '0) && (bus.RszPxlY == '0);
    assign in_eol   = (bus.RszPxlX == RSZ_X_LAST);
    assign in_eof   = in_eol && (bus.RszPxlY == RSZ_Y_LAST);
    assign acc      = bus.RszPxlVld & fifo_rdy;
    assign pop      = bus.OutRdy & ~fifo_empty;
    assign push_ent = '{data: bus.RszPxlData, sof: in_sof, eol: in_eol, eof: in_eof};

    img_rsz_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (RszOutEntry_t)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (acc),
        .din_i   (push_ent),
        .pop_i   (pop),
        .dout_o  (pop_ent),
        .empty_o (fifo_empty),
        .rdy_o   (fifo_rdy)
    );

    // A 1x1 image carries SOF and EOF together and never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (acc && in_sof && !in_eof) state_d = ST_ACTIVE;
            ST_ACTIVE: if (acc && in_eof)            state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frm_cnt_d = frm_cnt_q;
        if (pop && pop_ent.eof) frm_cnt_d = frm_cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            frm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            frm_cnt_q <= frm_cnt_d;
        end
    end

`ifdef IMG_RSZ_OUT_SEQ_CHK_EN
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  exp_x_q, exp_x_d, base_x;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] exp_y_q, exp_y_d, base_y;
    logic                            seq_err_q, seq_err_d;

    // SOF resynchronises the expected position before comparing.
    always_comb begin
        base_x    = in_sof ? '0 : exp_x_q;
        base_y    = in_sof ? '0 : exp_y_q;
        exp_x_d   = exp_x_q;
        exp_y_d   = exp_y_q;
        seq_err_d = seq_err_q;
        if (acc) begin
            if ((bus.RszPxlX != base_x) || (bus.RszPxlY != base_y) ||
                (in_sof && state_q == ST_ACTIVE))
                seq_err_d = 1'b1;
            if (base_x == RSZ_X_LAST) begin
                exp_x_d = '0;
                exp_y_d = (base_y == RSZ_Y_LAST) ? '0 : base_y + 1'b1;
            end else begin
                exp_x_d = base_x + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            exp_x_q   <= '0;
            exp_y_q   <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_x_q   <= exp_x_d;
            exp_y_q   <= exp_y_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.SeqErr = seq_err_q;
`else
    assign bus.SeqErr = 1'b0;
`endif

    assign bus.RszPxlRdy = fifo_rdy;
    assign bus.OutVld    = ~fifo_empty;
    assign bus.OutData   = pop_ent.data;
    assign bus.OutSof    = pop_ent.sof;
    assign bus.OutEol    = pop_ent.eol;
    assign bus.OutEof    = pop_ent.eof;
    assign bus.FrmCnt    = frm_cnt_q;
    assign bus.Busy      = (state_q == ST_ACTIVE) || !fifo_empty;

endmodule
